// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select codes,
// the "operand not used" Tuse marker and the per-stage shadow descriptor.
package hazard_unit_pkg;

  localparam logic [1:0] FWD_NONE  = 2'd0;
  localparam logic [1:0] FWD_E     = 2'd1;
  localparam logic [1:0] FWD_M     = 2'd2;
  localparam logic [1:0] FWD_W     = 2'd3;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int MD_CNT_W = 4;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
  } stage_desc_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard-descriptor bundle between the D-stage controller (master) and the
// hazard unit (slave): D-instruction descriptors in, stall/forward selects out.
interface hazard_unit_if;

  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_tuse_rs;
  logic [1:0] D_tuse_rt;
  logic [4:0] D_a3;
  logic [1:0] D_tnew;
  logic       D_md_start;
  logic       D_md_div;
  logic       D_md_use;

  logic       stall;
  logic [1:0] fwd_rs_d;
  logic [1:0] fwd_rt_d;
  logic [1:0] fwd_rs_e;
  logic [1:0] fwd_rt_e;
  logic [1:0] fwd_rt_m;
  logic       md_busy;

  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_a3, D_tnew,
           D_md_start, D_md_div, D_md_use,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
  );

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_a3, D_tnew,
           D_md_start, D_md_div, D_md_use,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
  );

endinterface

// File: rtl/hazard_unit_md_busy_counter.sv
// HI/LO busy window: loads the mult/div latency when a multiply/divide sits in
// E, then counts down; busy covers the E cycle itself plus the countdown.
module hazard_unit_md_busy_counter
  import hazard_unit_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic [MD_CNT_W-1:0] i_load_val,
  output logic                o_busy
);

  logic [MD_CNT_W-1:0] r_count;

  // Load has priority over the decrement of an in-flight count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - MD_CNT_W'(1);
    end
  end

  assign o_busy = i_load | (r_count != '0);

endmodule

// File: rtl/hazard_unit.sv
// Five-stage MIPS stall/forward controller: shadows E/M/W destination and
// remaining Tnew, and derives the D stall plus all forward-mux selects.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  hazard_unit_if.slave hif
);

  logic [4:0]          r_rs_p0;
  logic [4:0]          r_rt_p0;
  stage_desc_t         r_desc_p0;
  logic                r_md_start_p0;
  logic                r_md_div_p0;
  logic [4:0]          r_rt_p1;
  stage_desc_t         r_desc_p1;
  logic [4:0]          r_a3_p2;

  logic                w_stall;
  logic                w_md_busy;
  logic [MD_CNT_W-1:0] w_md_load_val;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic hit(input logic [4:0] a3, input logic [4:0] r);
    return (a3 == r) && (r != 5'd0);
  endfunction

  function automatic logic need_stall(input stage_desc_t e, input stage_desc_t m,
                                      input logic [4:0] r, input logic [1:0] tuse);
    return (tuse != TUSE_NONE) &&
           ((hit(e.a3, r) && (e.tnew > tuse)) || (hit(m.a3, r) && (m.tnew > tuse)));
  endfunction

  // A stage only supplies a value once its Tnew has reached zero; W always has.
  function automatic logic [1:0] fwd_sel_d(input stage_desc_t e, input stage_desc_t m,
                                           input logic [4:0] w_a3, input logic [4:0] r);
    if (hit(e.a3, r) && (e.tnew == 2'd0))      return FWD_E;
    else if (hit(m.a3, r) && (m.tnew == 2'd0)) return FWD_M;
    else if (hit(w_a3, r))                     return FWD_W;
    else                                       return FWD_NONE;
  endfunction

  function automatic logic [1:0] fwd_sel_e(input stage_desc_t m, input logic [4:0] w_a3,
                                           input logic [4:0] r);
    if (hit(m.a3, r) && (m.tnew == 2'd0)) return FWD_M;
    else if (hit(w_a3, r))                return FWD_W;
    else                                  return FWD_NONE;
  endfunction

  assign w_md_load_val = r_md_div_p0 ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);

  hazard_unit_md_busy_counter u_md_busy_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (r_md_start_p0),
    .i_load_val (w_md_load_val),
    .o_busy     (w_md_busy)
  );

  assign w_stall = need_stall(r_desc_p0, r_desc_p1, hif.D_rs, hif.D_tuse_rs)
                 | need_stall(r_desc_p0, r_desc_p1, hif.D_rt, hif.D_tuse_rt)
                 | (hif.D_md_use & w_md_busy);

  assign hif.stall    = w_stall;
  assign hif.md_busy  = w_md_busy;
  assign hif.fwd_rs_d = fwd_sel_d(r_desc_p0, r_desc_p1, r_a3_p2, hif.D_rs);
  assign hif.fwd_rt_d = fwd_sel_d(r_desc_p0, r_desc_p1, r_a3_p2, hif.D_rt);
  assign hif.fwd_rs_e = fwd_sel_e(r_desc_p1, r_a3_p2, r_rs_p0);
  assign hif.fwd_rt_e = fwd_sel_e(r_desc_p1, r_a3_p2, r_rt_p0);
  assign hif.fwd_rt_m = hit(r_a3_p2, r_rt_p1) ? FWD_W : FWD_NONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rs_p0       <= '0;
      r_rt_p0       <= '0;
      r_desc_p0     <= '0;
      r_md_start_p0 <= 1'b0;
      r_md_div_p0   <= 1'b0;
      r_rt_p1       <= '0;
      r_desc_p1     <= '0;
      r_a3_p2       <= '0;
    end else begin
      // M -> W
      r_a3_p2        <= r_desc_p1.a3;
      // E -> M
      r_rt_p1        <= r_rt_p0;
      r_desc_p1.a3   <= r_desc_p0.a3;
      r_desc_p1.tnew <= sat_dec(r_desc_p0.tnew);
      // D -> E: a stalled D instruction leaves a bubble behind it
      if (w_stall) begin
        r_rs_p0       <= '0;
        r_rt_p0       <= '0;
        r_desc_p0     <= '0;
        r_md_start_p0 <= 1'b0;
        r_md_div_p0   <= 1'b0;
      end else begin
        r_rs_p0        <= hif.D_rs;
        r_rt_p0        <= hif.D_rt;
        r_desc_p0.a3   <= hif.D_a3;
        r_desc_p0.tnew <= hif.D_tnew;
        r_md_start_p0  <= hif.D_md_start;
        r_md_div_p0    <= hif.D_md_div;
      end
    end
  end

endmodule
